// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file geometry and types
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0]     word_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner,
  output logic               any_grant
);

  int idx;

  // Scan from the farthest slot back to ptr so the closest valid requester wins last.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        winner    = PTR_W'(idx);
        any_grant = 1'b1;
      end
    end
    if (any_grant) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - round-robin shared read port for the register file
// REGFILE_BYPASS_EN enables same-cycle write forwarding onto resp_data.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = WORD_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         mux_select,
  input  logic [DATA_W-1:0]         mux_data,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ADDR_W-1:0]         resp_addr
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d, winner;
  logic [NUM_REQ-1:0] grant, resp_valid_q, resp_valid_d;
  logic               any_grant, grant_ok;
  logic [ADDR_W-1:0]  sel_q, sel_d, win_addr, resp_addr_q, resp_addr_d;
  logic [DATA_W-1:0]  rd_word, resp_data_q, resp_data_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  assign grant_ok   = any_grant & reset_n;
  assign req_ready  = reset_n ? grant : '0;
  assign win_addr   = req_addr[int'(winner)*ADDR_W +: ADDR_W];
  // Idle cycles keep the last select so the 32:1 mux does not toggle.
  assign mux_select = grant_ok ? win_addr : sel_q;

  always_comb begin
    rd_word = mux_data;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr == win_addr) && (wr_addr != ADDR_W'(ZERO_REG))) rd_word = wr_data;
`endif
    if (win_addr == ADDR_W'(ZERO_REG)) rd_word = '0;
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_comb begin
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    resp_addr_d  = resp_addr_q;
    if (grant_ok) begin
      ptr_d        = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
      sel_d        = win_addr;
      resp_valid_d = grant;
      resp_data_d  = rd_word;
      resp_addr_d  = win_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      sel_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_addr_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_addr_q  <= resp_addr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_addr  = resp_addr_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - vector table, corner sequences and randomized model check
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  req_ready;
  logic [4:0]  mux_select;
  logic [31:0] mux_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_addr;

  logic [31:0] rf [32];
  logic        use_model;
  logic [31:0] mux_drv;

  int n_cmp = 0;
  int n_fail = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  assign mux_data = use_model ? rf[mux_select] : mux_drv;

  regfile_read_arbiter #(.NUM_REQ(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .mux_select (mux_select),
    .mux_data   (mux_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [19:0] addr;
    logic [31:0] mux;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  e_ready;
    logic [4:0]  e_sel;
    logic [3:0]  e_rv;
    logic [31:0] e_rd;
    logic [4:0]  e_ra;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [19:0] a, input logic [31:0] m,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [3:0] er, input logic [4:0] es, input logic [3:0] ev,
                              input logic [31:0] ed, input logic [4:0] ea);
    vec_t t;
    t.valid = v; t.addr = a; t.mux = m; t.wen = we; t.waddr = wa; t.wdata = wd;
    t.e_ready = er; t.e_sel = es; t.e_rv = ev; t.e_rd = ed; t.e_ra = ea;
    return t;
  endfunction

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  initial begin
    int m_ptr, w;
    logic [4:0]  m_hold, m_ra, a;
    logic [3:0]  m_rv, e_ready;
    logic [31:0] m_rd, e_rd;
    logic        rst;

    tbl[0]  = mk(4'hF, pk(3,4,5,6), 32'h11, 0, 0, 0, 4'b0001, 5'd3, 4'b0001, 32'h11, 5'd3);
    tbl[1]  = mk(4'b0100, pk(0,0,7,0), 32'hDEADBEEF, 0, 0, 0, 4'b0100, 5'd7, 4'b0100, 32'hDEADBEEF, 5'd7);
    tbl[2]  = mk(4'b1000, pk(0,0,0,8), 32'h33, 0, 0, 0, 4'b1000, 5'd8, 4'b1000, 32'h33, 5'd8);
    for (int k = 0; k < 8; k++)
      tbl[3+k] = mk(4'hF, pk(1,2,3,4), 32'h100 + k, 0, 0, 0, 4'(1 << (k % 4)), 5'(k % 4 + 1),
                    4'(1 << (k % 4)), 32'h100 + k, 5'(k % 4 + 1));
    tbl[11] = mk(4'b0010, pk(0,0,0,0), 32'hFFFFFFFF, 0, 0, 0, 4'b0010, 5'd0, 4'b0010, 32'h0, 5'd0);
    tbl[12] = mk(4'b0001, pk(0,0,0,0), 32'hFFFFFFFF, 1, 5'd0, 32'hCAFE, 4'b0001, 5'd0, 4'b0001, 32'h0, 5'd0);
    tbl[13] = mk(4'b0100, pk(0,0,9,0), 32'hAAAA0000, 1, 5'd9, 32'h12345678, 4'b0100, 5'd9, 4'b0100,
                 BYP ? 32'h12345678 : 32'hAAAA0000, 5'd9);
    tbl[14] = mk(4'b1000, pk(0,0,0,5), 32'h55, 0, 0, 0, 4'b1000, 5'd5, 4'b1000, 32'h55, 5'd5);
    tbl[15] = mk(4'b0000, pk(31,31,31,31), 32'h66, 0, 0, 0, 4'b0000, 5'd5, 4'b0000, 32'h55, 5'd5);
    tbl[16] = mk(4'b0000, pk(1,2,3,4), 32'h67, 1, 5'd5, 32'h1, 4'b0000, 5'd5, 4'b0000, 32'h55, 5'd5);

    use_model = 1'b0; mux_drv = 32'h0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    reset_n = 1'b0; req_valid = 4'hF; req_addr = pk(3,4,5,6);

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("reset_ready", req_ready, 4'h0);
      @(posedge clk); #1;
      chk("reset_rv", resp_valid, 4'h0);
      chk("reset_rd", resp_data, 32'h0);
    end
    chk("reset_sel", mux_select, 5'd0);
    chk("reset_ra", resp_addr, 5'd0);

    reset_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      req_valid = tbl[i].valid; req_addr = tbl[i].addr; mux_drv = tbl[i].mux;
      wr_en = tbl[i].wen; wr_addr = tbl[i].waddr; wr_data = tbl[i].wdata;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), req_ready, tbl[i].e_ready);
      chk($sformatf("v%0d_sel", i), mux_select, tbl[i].e_sel);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rv", i), resp_valid, tbl[i].e_rv);
      chk($sformatf("v%0d_rd", i), resp_data, tbl[i].e_rd);
      chk($sformatf("v%0d_ra", i), resp_addr, tbl[i].e_ra);
    end

    // Grant, then reset on the following cycle: the response is dropped and select clears.
    wr_en = 1'b0; req_valid = 4'b0001; req_addr = pk(12,0,0,0); mux_drv = 32'h77;
    @(negedge clk);
    chk("mf_ready", req_ready, 4'b0001);
    chk("mf_sel", mux_select, 5'd12);
    @(posedge clk); #1;
    chk("mf_rv", resp_valid, 4'b0001);
    reset_n = 1'b0; req_valid = 4'hF;
    @(negedge clk);
    chk("mf_rst_ready", req_ready, 4'h0);
    @(posedge clk); #1;
    chk("mf_rst_rv", resp_valid, 4'h0);
    chk("mf_rst_sel", mux_select, 5'd0);
    chk("mf_rst_rd", resp_data, 32'h0);
    reset_n = 1'b1; req_addr = pk(3,4,5,6); mux_drv = 32'h99;
    @(negedge clk);
    chk("mf_rel_ready", req_ready, 4'b0001);
    @(posedge clk); #1;

    m_ptr = 1; m_hold = 5'd3; m_rv = 4'b0001; m_rd = 32'h99; m_ra = 5'd3;
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    use_model = 1'b1;

    for (int it = 0; it < 400; it++) begin
      rst = ($urandom_range(0, 39) == 0);
      reset_n = !rst;
      req_valid = 4'($urandom_range(0, 15));
      for (int j = 0; j < 4; j++)
        req_addr[j*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 1) == 1) ? req_addr[$urandom_range(0, 3)*5 +: 5] : 5'($urandom_range(0, 31));
      wr_data = $urandom;

      w = rst ? -1 : pick(req_valid, m_ptr);
      a = (w >= 0) ? req_addr[w*5 +: 5] : m_hold;
      e_ready = (w >= 0) ? 4'(1 << w) : 4'h0;
      if (a == 5'd0) e_rd = 32'h0;
      else if (BYP && wr_en && wr_addr == a) e_rd = wr_data;
      else e_rd = rf[a];

      @(negedge clk);
      chk($sformatf("r%0d_ready", it), req_ready, e_ready);
      chk($sformatf("r%0d_sel", it), mux_select, a);
      @(posedge clk); #1;
      if (wr_en) rf[wr_addr] = wr_data;

      if (rst) begin
        m_ptr = 0; m_hold = 5'd0; m_rv = 4'h0; m_rd = 32'h0; m_ra = 5'd0;
      end else if (w >= 0) begin
        m_ptr = (w + 1) % 4; m_hold = a; m_rv = e_ready; m_rd = e_rd; m_ra = a;
      end else begin
        m_rv = 4'h0;
      end
      chk($sformatf("r%0d_rv", it), resp_valid, m_rv);
      chk($sformatf("r%0d_rd", it), resp_data, m_rd);
      chk($sformatf("r%0d_ra", it), resp_addr, m_ra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
